vector_capture_monitor: RTL and testbench

//   Hardware counterpart of a file-driven vector bench: records a DUT's signals instead of

---
 rtl/vector_capture_monitor.sv | 121 ++++++++++++
 tb/tb_vector_capture_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vector_capture_monitor.sv
// On-chip logic analyser: while capturing, stores {timestamp, sample} into a show-ahead FIFO
// whenever the probe vector changes; a valid/ready port drains the FIFO.
module vector_capture_monitor #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 16,
   parameter int TSW   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      stop,
   input  logic [WIDTH-1:0]          sample,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [TSW+WIDTH-1:0]      out_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      busy,
   output logic                      overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, CAPTURE} state_t;

   state_t                 state_q, state_d;
   logic [TSW-1:0]         ts_q, ts_d;
   logic                   first_q, first_d;
   logic [WIDTH-1:0]       last_q, last_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic [TSW+WIDTH-1:0]   mem_q [DEPTH];

   logic full, pop, start_go, capture, push_req, push_en;

   always_comb begin
      full     = (count_q == CW'(DEPTH));
      pop      = (count_q != '0) && out_ready;
      start_go = start && !stop;
      // The start and stop edges themselves never sample the probe.
      capture  = (state_q == CAPTURE) && !stop && !start_go;
      push_req = capture && (first_q || (sample != last_q));
      push_en  = push_req && (!full || pop);

      state_d    = state_q;
      ts_d       = ts_q;
      first_d    = first_q;
      last_d     = last_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (start_go) begin
         state_d    = CAPTURE;
         ts_d       = '0;
         first_d    = 1'b1;
         overflow_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (stop)
            state_d = IDLE;
         if (capture) begin
            last_d  = sample;
            first_d = 1'b0;
            if (ts_q != '1)
               ts_d = ts_q + TSW'(1);
            if (push_req && full && !pop)
               overflow_d = 1'b1;
         end
         if (push_en)
            wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ts_q       <= '0;
         first_q    <= 1'b1;
         last_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         first_q    <= first_d;
         last_q     <= last_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_en)
         mem_q[wr_ptr_q] <= {ts_q, sample};
   end

   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign count     = count_q;
   assign busy      = (state_q == CAPTURE);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_vector_capture_monitor.sv
// Directed bench for vector_capture_monitor: default instance plus a TSW=4 instance for saturation.
module tb_vector_capture_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop, out_ready;
   logic [2:0]  sample;
   logic        out_valid, busy, overflow;
   logic [18:0] out_data;
   logic [4:0]  count;

   logic        start2, out_ready2;
   logic [2:0]  sample2;
   logic        out_valid2, busy2, overflow2;
   logic [6:0]  out_data2;
   logic [4:0]  count2;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   vector_capture_monitor #(.WIDTH(3), .DEPTH(16), .TSW(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .sample(sample),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .busy(busy), .overflow(overflow)
   );

   vector_capture_monitor #(.WIDTH(3), .DEPTH(16), .TSW(4)) u_dut_ts4 (
      .clk(clk), .rst_n(rst_n), .start(start2), .stop(1'b0), .sample(sample2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .count(count2), .busy(busy2), .overflow(overflow2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [2:0] pat(input int unsigned i);
      return (i % 2 == 1) ? 3'b101 : 3'b010;
   endfunction

   function automatic logic [63:0] ent(input int unsigned ts, input logic [2:0] s);
      return (64'(ts) << 3) | 64'(s);
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0; sample = 3'b000;
      start2 = 1'b0; out_ready2 = 1'b0; sample2 = 3'b000;
      tick(); tick();
      check("rst_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      rst_n = 1'b1;
      tick();

      // Asynchronous reset mid-capture with five entries held
      do_start();
      check("t1_busy", busy, 1);
      for (int unsigned i = 0; i < 5; i++) begin
         sample = 3'(i);
         tick();
      end
      check("t1_count5", count, 5);
      #2 rst_n = 1'b0;
      #1;
      check("t1_async_valid", out_valid, 0);
      check("t1_async_count", count, 0);
      check("t1_async_busy", busy, 0);
      check("t1_async_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Change detection and one-cycle visibility
      out_ready = 1'b1;
      sample = 3'b000;
      do_start();
      check("t2_pre_valid", out_valid, 0);
      tick();
      check("t2_e1_valid", out_valid, 1);
      check("t2_e1_data", out_data, ent(0, 3'b000));
      tick();
      check("t2_e2_valid", out_valid, 0);
      tick();
      check("t2_e3_valid", out_valid, 0);
      sample = 3'b101;
      tick();
      check("t2_e4_valid", out_valid, 1);
      check("t2_e4_data", out_data, ent(3, 3'b101));
      tick();
      check("t2_e5_valid", out_valid, 0);
      check("t2_e5_count", count, 0);

      // Overflow with no consumer, then in-order drain
      out_ready = 1'b0;
      do_start();
      for (int unsigned i = 0; i < 20; i++) begin
         sample = pat(i);
         tick();
      end
      check("t3_count", count, 16);
      check("t3_ovf", overflow, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t3_idle", busy, 0);
      for (int unsigned i = 0; i < 16; i++) begin
         check($sformatf("t3_drain%0d", i), out_data, ent(i, pat(i)));
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      check("t3_empty", out_valid, 0);
      check("t3_ovf_sticky", overflow, 1);

      // Push and pop together while full
      do_start();
      check("t4_ovf_clr", overflow, 0);
      for (int unsigned i = 0; i < 16; i++) begin
         sample = pat(i);
         tick();
      end
      check("t4_full", count, 16);
      sample = pat(16);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t4_count", count, 16);
      check("t4_ovf", overflow, 0);
      check("t4_head", out_data, ent(1, pat(1)));

      // start+stop together stops without flush; start alone restarts with flush
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("t5_idle", busy, 0);
      check("t5_noflush", count, 16);
      do_start();
      check("t5_flush_from_idle", count, 0);
      sample = 3'b011;
      tick();
      sample = 3'b100;
      tick();
      check("t5_count2", count, 2);
      do_start();
      check("t5_restart_busy", busy, 1);
      check("t5_restart_count", count, 0);
      tick();
      check("t5_restart_data", out_data, ent(0, 3'b100));

      // Timestamp saturation on the TSW=4 instance
      sample2 = 3'b001;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int unsigned i = 0; i < 20; i++)
         tick();
      sample2 = 3'b110;
      tick();
      check("t6_count", count2, 2);
      check("t6_head", out_data2, ent(0, 3'b001));
      out_ready2 = 1'b1;
      tick();
      out_ready2 = 1'b0;
      check("t6_sat_data", out_data2, ent(15, 3'b110));
      check("t6_count1", count2, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
